// File: rtl/obst_motion_ctl.sv
// Moves N_OBST obstacle rows between Y_MIN and Y_MAX, with a dwell at each end; all outputs registered, move 1 clk after last divider count, no backpressure.
// Optional OBST_WRAP_MODE_EN adds a 'wrap' input selecting down-only motion that wraps from bottom to top.
module obst_motion_ctl #(
  parameter int N_OBST     = 4,
  parameter int W          = 12,
  parameter int XPOS_BASE  = 600,
  parameter int XPOS_PITCH = 60,
  parameter int Y_MIN      = 1,
  parameter int Y_MAX      = 300,
  parameter int STEP       = 1,
  parameter int DIV        = 1,
  parameter int DWELL      = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                restart,
`ifdef OBST_WRAP_MODE_EN
  input  logic                wrap,
`endif
  output logic [N_OBST*W-1:0] xpos,
  output logic [N_OBST*W-1:0] ypos,
  output logic [N_OBST-1:0]   dir,
  output logic [N_OBST-1:0]   turn
);
  typedef enum logic [1:0] {ST_DOWN, ST_DWELL_BOT, ST_UP, ST_DWELL_TOP} state_t;

  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SPACING = (Y_MAX - Y_MIN) / N_OBST;
  localparam logic [W:0]       YMIN_X   = (W+1)'(Y_MIN);
  localparam logic [W:0]       YMAX_X   = (W+1)'(Y_MAX);
  localparam logic [W:0]       STEP_X   = (W+1)'(STEP);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'((DWELL > 0) ? DWELL - 1 : 0);

  function automatic logic [W-1:0] init_y(input int i);
    return W'(Y_MIN + i * SPACING);
  endfunction

  // Odd channels start upward; one already sitting on the top limit starts in its dwell.
  function automatic state_t init_st(input int i);
    if (i % 2 == 0) return ST_DOWN;
    return (init_y(i) == W'(Y_MIN)) ? ST_DWELL_TOP : ST_UP;
  endfunction

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick;
  logic [W-1:0]      ypos_q [N_OBST];
  logic [W-1:0]      ypos_d [N_OBST];
  state_t            st_q   [N_OBST];
  state_t            st_d   [N_OBST];
  logic [DW_W-1:0]   dcnt_q [N_OBST];
  logic [DW_W-1:0]   dcnt_d [N_OBST];
  logic [N_OBST-1:0] dir_q, dir_d, turn_q, turn_d;
  logic [W:0]        y_x;

  always_comb begin
    tick   = en && (div_q == DIV_LAST);
    div_d  = (restart || !en || tick) ? '0 : div_q + 1'b1;
    dir_d  = dir_q;
    turn_d = '0;
    y_x    = '0;
    for (int i = 0; i < N_OBST; i++) begin
      ypos_d[i] = ypos_q[i];
      st_d[i]   = st_q[i];
      dcnt_d[i] = dcnt_q[i];
      y_x       = {1'b0, ypos_q[i]};
      if (restart) begin
        ypos_d[i] = init_y(i);
        st_d[i]   = init_st(i);
        dcnt_d[i] = '0;
        dir_d[i]  = (i % 2 == 1);
      end else if (tick) begin
        case (st_q[i])
          ST_DOWN: begin
            if (y_x + STEP_X >= YMAX_X) begin
              ypos_d[i] = W'(Y_MAX);
              turn_d[i] = 1'b1;
              if (DWELL > 0) st_d[i] = ST_DWELL_BOT;
              else begin
                st_d[i]  = ST_UP;
                dir_d[i] = 1'b1;
              end
            end else begin
              ypos_d[i] = ypos_q[i] + W'(STEP);
            end
          end
          ST_DWELL_BOT: begin
            if (dcnt_q[i] == DW_LAST) begin
              dcnt_d[i] = '0;
              st_d[i]   = ST_UP;
              dir_d[i]  = 1'b1;
            end else begin
              dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
          end
          ST_UP: begin
            if (y_x <= YMIN_X + STEP_X) begin
              ypos_d[i] = W'(Y_MIN);
              turn_d[i] = 1'b1;
              if (DWELL > 0) st_d[i] = ST_DWELL_TOP;
              else begin
                st_d[i]  = ST_DOWN;
                dir_d[i] = 1'b0;
              end
            end else begin
              ypos_d[i] = ypos_q[i] - W'(STEP);
            end
          end
          ST_DWELL_TOP: begin
            if (dcnt_q[i] == DW_LAST) begin
              dcnt_d[i] = '0;
              st_d[i]   = ST_DOWN;
              dir_d[i]  = 1'b0;
            end else begin
              dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
          end
          default: begin
            st_d[i]  = ST_DOWN;
            dir_d[i] = 1'b0;
          end
        endcase
`ifdef OBST_WRAP_MODE_EN
        // Down-only motion overrides the bounce FSM; leaving it resumes DOWN from here.
        if (wrap) begin
          st_d[i]   = ST_DOWN;
          dcnt_d[i] = '0;
          dir_d[i]  = 1'b0;
          if (y_x + STEP_X > YMAX_X) begin
            ypos_d[i] = W'(Y_MIN);
            turn_d[i] = 1'b1;
          end else begin
            ypos_d[i] = ypos_q[i] + W'(STEP);
            turn_d[i] = 1'b0;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      turn_q <= '0;
      for (int i = 0; i < N_OBST; i++) begin
        ypos_q[i] <= init_y(i);
        st_q[i]   <= init_st(i);
        dcnt_q[i] <= '0;
        dir_q[i]  <= (i % 2 == 1);
      end
    end else begin
      div_q  <= div_d;
      turn_q <= turn_d;
      dir_q  <= dir_d;
      for (int i = 0; i < N_OBST; i++) begin
        ypos_q[i] <= ypos_d[i];
        st_q[i]   <= st_d[i];
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_OBST; g++) begin : g_out
    assign xpos[g*W +: W] = W'(XPOS_BASE + g * XPOS_PITCH);
    assign ypos[g*W +: W] = ypos_q[g];
  end
  assign dir  = dir_q;
  assign turn = turn_q;
endmodule

// File: tb/tb_obst_motion_ctl.sv
// Two controller configurations driven with shared random en/restart/reset, checked every cycle against a position/dwell model.
module tb_obst_motion_ctl;
  localparam int W = 12;
  localparam int AN = 4, BN = 3;
  localparam int P_N[2]    = '{4, 3};
  localparam int P_YMIN[2] = '{1, 2};
  localparam int P_YMAX[2] = '{300, 300};
  localparam int P_STEP[2] = '{1, 7};
  localparam int P_DIV[2]  = '{1, 4};
  localparam int P_DW[2]   = '{10, 3};
  localparam int P_XB[2]   = '{600, 100};
  localparam int P_XP[2]   = '{60, 25};

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, restart = 1'b0;
`ifdef OBST_WRAP_MODE_EN
  logic wrap = 1'b0;
`endif
  logic [AN*W-1:0] a_x, a_y;
  logic [AN-1:0]   a_dir, a_turn;
  logic [BN*W-1:0] b_x, b_y;
  logic [BN-1:0]   b_dir, b_turn;
  int n_tests = 0, n_fail = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  obst_motion_ctl #(.N_OBST(4), .W(W), .XPOS_BASE(600), .XPOS_PITCH(60), .Y_MIN(1),
                    .Y_MAX(300), .STEP(1), .DIV(1), .DWELL(10)) u_a (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
`ifdef OBST_WRAP_MODE_EN
    .wrap(wrap),
`endif
    .xpos(a_x), .ypos(a_y), .dir(a_dir), .turn(a_turn));

  obst_motion_ctl #(.N_OBST(3), .W(W), .XPOS_BASE(100), .XPOS_PITCH(25), .Y_MIN(2),
                    .Y_MAX(300), .STEP(7), .DIV(4), .DWELL(3)) u_b (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
`ifdef OBST_WRAP_MODE_EN
    .wrap(wrap),
`endif
    .xpos(b_x), .ypos(b_y), .dir(b_dir), .turn(b_turn));

  // Model: position, travel direction (the dir output) and ticks of dwell still to serve.
  int m_pos  [2][8];
  bit m_up   [2][8];
  int m_dw   [2][8];
  bit m_turn [2][8];
  int m_cnt  [2];

  task automatic model_init(input int k);
    m_cnt[k] = 0;
    for (int i = 0; i < P_N[k]; i++) begin
      m_pos[k][i]  = P_YMIN[k] + i * ((P_YMAX[k] - P_YMIN[k]) / P_N[k]);
      m_up[k][i]   = (i % 2 == 1);
      m_dw[k][i]   = (m_up[k][i] && m_pos[k][i] == P_YMIN[k]) ? P_DW[k] : 0;
      m_turn[k][i] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    bit tk;
    tk = en && (m_cnt[k] == P_DIV[k] - 1);
    m_cnt[k] = (en && !tk) ? m_cnt[k] + 1 : 0;
    for (int i = 0; i < P_N[k]; i++) begin
      m_turn[k][i] = 1'b0;
      if (tk) begin
        if (m_dw[k][i] > 0) begin
          m_dw[k][i]--;
          if (m_dw[k][i] == 0) m_up[k][i] = !m_up[k][i];
        end else if (!m_up[k][i]) begin
          if (m_pos[k][i] + P_STEP[k] >= P_YMAX[k]) begin
            m_pos[k][i] = P_YMAX[k];
            m_turn[k][i] = 1'b1;
            if (P_DW[k] > 0) m_dw[k][i] = P_DW[k]; else m_up[k][i] = 1'b1;
          end else m_pos[k][i] += P_STEP[k];
        end else begin
          if (m_pos[k][i] <= P_YMIN[k] + P_STEP[k]) begin
            m_pos[k][i] = P_YMIN[k];
            m_turn[k][i] = 1'b1;
            if (P_DW[k] > 0) m_dw[k][i] = P_DW[k]; else m_up[k][i] = 1'b0;
          end else m_pos[k][i] -= P_STEP[k];
        end
      end
    end
  endtask

  always @(negedge rst) begin
    model_init(0);
    model_init(1);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst || restart) model_init(k);
      else model_step(k);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < AN; i++) begin
      chk($sformatf("A.ypos[%0d]", i), 32'(a_y[i*W +: W]), m_pos[0][i]);
      chk($sformatf("A.xpos[%0d]", i), 32'(a_x[i*W +: W]), P_XB[0] + i * P_XP[0]);
      chk($sformatf("A.dir[%0d]", i), 32'(a_dir[i]), int'(m_up[0][i]));
      chk($sformatf("A.turn[%0d]", i), 32'(a_turn[i]), int'(m_turn[0][i]));
    end
    for (int i = 0; i < BN; i++) begin
      chk($sformatf("B.ypos[%0d]", i), 32'(b_y[i*W +: W]), m_pos[1][i]);
      chk($sformatf("B.xpos[%0d]", i), 32'(b_x[i*W +: W]), P_XB[1] + i * P_XP[1]);
      chk($sformatf("B.dir[%0d]", i), 32'(b_dir[i]), int'(m_up[1][i]));
      chk($sformatf("B.turn[%0d]", i), 32'(b_turn[i]), int'(m_turn[1][i]));
    end
  endtask

  always @(negedge clk) if (cmp_on) compare_all();

  // Hand-computed start state, independent of the model.
  task automatic chk_init(input string tag);
    int ea_y[4] = '{1, 75, 149, 223};
    int ea_x[4] = '{600, 660, 720, 780};
    int eb_y[3] = '{2, 101, 200};
    int eb_x[3] = '{100, 125, 150};
    for (int i = 0; i < 4; i++) begin
      chk({tag, " A.ypos"}, 32'(a_y[i*W +: W]), ea_y[i]);
      chk({tag, " A.xpos"}, 32'(a_x[i*W +: W]), ea_x[i]);
    end
    for (int i = 0; i < 3; i++) begin
      chk({tag, " B.ypos"}, 32'(b_y[i*W +: W]), eb_y[i]);
      chk({tag, " B.xpos"}, 32'(b_x[i*W +: W]), eb_x[i]);
    end
    chk({tag, " A.dir"}, 32'(a_dir), 'b1010);
    chk({tag, " B.dir"}, 32'(b_dir), 'b010);
    chk({tag, " A.turn"}, 32'(a_turn), 0);
    chk({tag, " B.turn"}, 32'(b_turn), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_init(0);
    model_init(1);
    #1 rst = 1'b0;
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    chk_init("reset");
    #1 rst = 1'b1; en = 1'b1;

    // Continuous run: A ch0 rises 1->300 then dwells; B ch0 steps by 7 and clamps.
    for (int n = 1; n <= 310; n++) begin
      @(negedge clk);
      if (n == 298) chk("A ch0 before bottom", 32'(a_y[0 +: W]), 299);
      if (n == 299) begin
        chk("A ch0 at bottom", 32'(a_y[0 +: W]), 300);
        chk("A turn0 at bottom", 32'(a_turn[0]), 1);
        chk("A dir0 at bottom", 32'(a_dir[0]), 0);
      end
      if (n == 300) chk("A turn0 one clk", 32'(a_turn[0]), 0);
      if (n == 308) chk("A dir0 still dwelling", 32'(a_dir[0]), 0);
      if (n == 309) begin
        chk("A dir0 after dwell", 32'(a_dir[0]), 1);
        chk("A ch0 held 300", 32'(a_y[0 +: W]), 300);
      end
      if (n == 310) chk("A ch0 leaves bottom", 32'(a_y[0 +: W]), 299);
      if (n == 171) chk("B ch0 at 296", 32'(b_y[0 +: W]), 296);
      if (n == 172) begin
        chk("B ch0 clamped", 32'(b_y[0 +: W]), 300);
        chk("B turn0 clamp", 32'(b_turn[0]), 1);
      end
    end

    // en dropped mid-count with DIV=4.
    #1 en = 1'b0; restart = 1'b1;
    @(negedge clk);
    chk_init("restart");
    #1 restart = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    #1 en = 1'b0;
    repeat (3) @(negedge clk);
    chk("A ch0 holds while en=0", 32'(a_y[0 +: W]), 3);
    chk("B ch0 holds while en=0", 32'(b_y[0 +: W]), 2);
    #1 en = 1'b1;
    repeat (3) @(negedge clk);
    chk("B ch0 before divider wraps", 32'(b_y[0 +: W]), 2);
    @(negedge clk);
    chk("B ch0 4 clks after en", 32'(b_y[0 +: W]), 9);

    // Restart while A ch2 dwells at the bottom (restart also beats en).
    #1 restart = 1'b1; en = 1'b0;
    @(negedge clk);
    #1 restart = 1'b0; en = 1'b1;
    repeat (155) @(negedge clk);
    chk("A ch2 dwelling at bottom", 32'(a_y[2*W +: W]), 300);
    chk("A dir2 dwelling", 32'(a_dir[2]), 0);
    #1 restart = 1'b1;
    @(negedge clk);
    chk_init("restart in dwell");
    #1 restart = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_init("async reset");
    @(negedge clk);
    #1 rst = 1'b1;

    // Random phase.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      en      = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    #1 en = 1'b0; restart = 1'b0;
    @(negedge clk);
    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
